// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: holds predicted branches in fetch order
// and reports predictor updates and mispredict redirects.
module branch_resolve_queue #(
  parameter int BIT_WIDTH = 32,
  parameter int DEPTH     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq,
  input  logic [BIT_WIDTH-1:0]   enq_pc,
  input  logic                   enq_pred,
  input  logic [BIT_WIDTH-1:0]   enq_target,
  input  logic                   resolve,
  input  logic                   res_taken,
  input  logic [BIT_WIDTH-1:0]   res_target,
  output logic                   update,
  output logic [BIT_WIDTH-1:0]   update_pc,
  output logic                   reality,
  output logic                   mispredict,
  output logic [BIT_WIDTH-1:0]   redirect_pc,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [BIT_WIDTH-1:0] pc_mem  [DEPTH];
  logic [BIT_WIDTH-1:0] tgt_mem [DEPTH];
  logic                 pred_mem[DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  logic                 update_q;
  logic [BIT_WIDTH-1:0] update_pc_q;
  logic                 reality_q;
  logic                 mispredict_q;
  logic [BIT_WIDTH-1:0] redirect_q;
  logic                 overflow_q;
  logic                 underflow_q;

  logic [BIT_WIDTH-1:0] h_pc;
  logic [BIT_WIDTH-1:0] h_tgt;
  logic                 h_pred;
  logic                 res_ok;
  logic                 mis_now;
  logic                 pop;
  logic                 push;
  logic                 ovf_now;
  logic [BIT_WIDTH-1:0] redir_now;

  assign h_pc   = pc_mem[head_q];
  assign h_tgt  = tgt_mem[head_q];
  assign h_pred = pred_mem[head_q];

  assign res_ok  = resolve & (count_q != '0);
  assign mis_now = res_ok &
                   ((h_pred != res_taken) |
                    (h_pred & res_taken &
                     (h_tgt != res_target)));
  assign pop     = res_ok & ~mis_now;
  // A correct resolve frees a slot this cycle, so a full
  // queue can still take the same-cycle enqueue.
  assign push    = enq & ~mis_now &
                   ((count_q != FULL_CNT) | res_ok);
  assign ovf_now = enq & ~mis_now & ~push;

  assign redir_now = res_taken ? res_target
                               : h_pc + BIT_WIDTH'(4);

  // Next pointer/occupancy; a mispredict flushes everything.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mis_now) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (pop)
        head_d = head_q + PTR_ONE;
      if (push)
        tail_d = tail_q + PTR_ONE;
      if (push & ~pop)
        count_d = count_q + CNT_ONE;
      else if (pop & ~push)
        count_d = count_q - CNT_ONE;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]   <= enq_pc;
      tgt_mem[tail_q]  <= enq_target;
      pred_mem[tail_q] <= enq_pred;
    end
  end

  // Control state, registered strobes and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      update_q     <= 1'b0;
      update_pc_q  <= '0;
      reality_q    <= 1'b0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      update_q     <= res_ok;
      mispredict_q <= mis_now;
      if (res_ok) begin
        update_pc_q <= h_pc;
        reality_q   <= res_taken;
      end
      if (mis_now)
        redirect_q <= redir_now;
      if (ovf_now)
        overflow_q <= 1'b1;
      if (resolve & ~res_ok)
        underflow_q <= 1'b1;
    end
  end

  assign update      = update_q;
  assign update_pc   = update_pc_q;
  assign reality     = reality_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_q;
  assign count       = count_q;
  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_branch_resolve_queue;

  localparam int BW = 32;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          enq;
  logic [BW-1:0] enq_pc;
  logic          enq_pred;
  logic [BW-1:0] enq_target;
  logic          resolve;
  logic          res_taken;
  logic [BW-1:0] res_target;
  logic          update;
  logic [BW-1:0] update_pc;
  logic          reality;
  logic          mispredict;
  logic [BW-1:0] redirect_pc;
  logic          full;
  logic          empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;

  branch_resolve_queue #(
    .BIT_WIDTH(BW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enq(enq),
    .enq_pc(enq_pc),
    .enq_pred(enq_pred),
    .enq_target(enq_target),
    .resolve(resolve),
    .res_taken(res_taken),
    .res_target(res_target),
    .update(update),
    .update_pc(update_pc),
    .reality(reality),
    .mispredict(mispredict),
    .redirect_pc(redirect_pc),
    .full(full),
    .empty(empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] pc;
    bit            pred;
    logic [BW-1:0] tgt;
  } ent_t;

  ent_t          mq[$];
  bit            m_upd;
  bit            m_mis;
  bit            m_real;
  bit            m_ovf;
  bit            m_unf;
  logic [BW-1:0] m_upc;
  logic [BW-1:0] m_redir;

  int n_chk;
  int n_pass;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
  endtask

  // Reference: queue of pending branches, one step per edge.
  task automatic model();
    ent_t e;
    bit   flush;
    flush = 0;
    if (rst) begin
      mq.delete();
      m_upd = 0; m_mis = 0; m_real = 0;
      m_ovf = 0; m_unf = 0;
      m_upc = '0; m_redir = '0;
      return;
    end
    m_upd = 0;
    m_mis = 0;
    if (resolve) begin
      if (mq.size() == 0) begin
        m_unf = 1;
      end else begin
        e = mq.pop_front();
        m_upd = 1;
        m_upc = e.pc;
        m_real = res_taken;
        if (e.pred != res_taken ||
            (res_taken && e.tgt != res_target)) begin
          flush = 1;
          m_mis = 1;
          m_redir = res_taken ? res_target : e.pc + 32'd4;
          mq.delete();
        end
      end
    end
    if (enq && !flush) begin
      if (mq.size() < DEPTH)
        mq.push_back('{enq_pc, enq_pred, enq_target});
      else
        m_ovf = 1;
    end
  endtask

  task automatic check_all();
    chk("update", update, m_upd);
    chk("mispredict", mispredict, m_mis);
    chk("update_pc", update_pc, m_upc);
    chk("reality", reality, m_real);
    chk("redirect_pc", redirect_pc, m_redir);
    chk("count", count, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("empty", empty, mq.size() == 0);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
  endtask

  task automatic step(input bit r, input bit e,
                      input logic [BW-1:0] pc,
                      input bit pr,
                      input logic [BW-1:0] tg,
                      input bit rs, input bit rt,
                      input logic [BW-1:0] rtg);
    rst = r; enq = e; enq_pc = pc;
    enq_pred = pr; enq_target = tg;
    resolve = rs; res_taken = rt; res_target = rtg;
    model();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_rst();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1; enq = 0; enq_pc = 0; enq_pred = 0;
    enq_target = 0; resolve = 0; res_taken = 0;
    res_target = 0;

    // reset state
    do_rst();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);

    // correct taken resolve
    step(0, 1, 32'h100, 1, 32'h200, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'h200);
    chk("c34_upc", update_pc, 32'h100);
    chk("c34_mis", mispredict, 0);
    idle();

    // direction mispredict, flush behind it
    step(0, 1, 32'h40, 1, 32'h80, 0, 0, 0);
    step(0, 1, 32'h44, 0, 32'h90, 0, 0, 0);
    step(0, 1, 32'h48, 0, 32'h94, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    chk("c35_redir", redirect_pc, 32'h44);
    chk("c35_empty", empty, 1);
    idle();

    // fill, overflow, then pop+push while full
    do_rst();
    for (int i = 0; i < DEPTH; i++)
      step(0, 1, 32'h1000 + 4 * i, 0, 0, 0, 0, 0);
    step(0, 1, 32'hdead, 0, 0, 0, 0, 0);
    chk("c36_ovf", overflow, 1);
    step(0, 1, 32'h2000, 0, 0, 1, 0, 0);
    chk("c36_cnt", count, 8);
    chk("c36_upc", update_pc, 32'h1000);
    for (int i = 0; i < DEPTH; i++)
      step(0, 0, 0, 0, 0, 1, 0, 0);

    // underflow is sticky until reset
    do_rst();
    step(0, 0, 0, 0, 0, 1, 1, 32'h10);
    chk("c37_unf", underflow, 1);
    chk("c37_upd", update, 0);
    idle();
    idle();
    do_rst();

    // target mispredict with same-cycle enqueue dropped
    step(0, 1, 32'h80, 1, 32'h300, 0, 0, 0);
    step(0, 1, 32'h84, 0, 0, 1, 1, 32'h304);
    chk("c38_redir", redirect_pc, 32'h304);
    chk("c38_cnt", count, 0);
    idle();

    // reset wins over resolve
    do_rst();
    for (int i = 0; i < 3; i++)
      step(0, 1, 32'h500 + 4 * i, 1, 32'h600, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 32'h600);
    idle();
    chk("c39_upd", update, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bit            r, e, pr, rs, rt;
      logic [BW-1:0] pc, tg, rtg;
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 99) < 60);
      pr = $urandom_range(0, 1);
      pc = {$urandom_range(0, 255), 2'b00};
      tg = {$urandom_range(0, 7), 4'h0};
      rs = ($urandom_range(0, 99) < 45);
      rt = $urandom_range(0, 1);
      rtg = {$urandom_range(0, 7), 4'h0};
      if (mq.size() != 0 && $urandom_range(0, 3) != 0) begin
        rt  = mq[0].pred;
        rtg = mq[0].tgt;
      end
      step(r, e, pc, pr, tg, rs, rt, rtg);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
